// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice: opcodes, FSM encoding
// and the default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU shared by both requesters. The reserved opcode
// yields a zero result and raises err.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic [WIDTH-1:0] xor_s;

  generate
    if (WIDTH == 32) begin : g_xor32
      myXor_32bit u_xor (
        .a (a),
        .b (b),
        .y (xor_s)
      );
    end else begin : g_xorn
      assign xor_s = a ^ b;
    end
  endgenerate

  // Opcode decode and result selection; SLT compares as two's complement.
  always_comb begin
    result = {WIDTH{1'b0}};
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = xor_s;
      OP_NOR:  result = ~(a | b);
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_RSVD: begin
        result = {WIDTH{1'b0}};
        err    = 1'b1;
      end
      default: begin
        result = {WIDTH{1'b0}};
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/myXor_32bit.sv
// 32-bit XOR built from one XOR cell per bit.
module myXor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      xor u_cell (y[i], a[i], b[i]);
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin front end for one shared ALU: grants one of two requesters,
// latches its operands, evaluates once and returns a tagged, held response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_grant_r;
  logic             grant_id_s;
  logic             any_valid_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_err_s;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_res_s),
    .err    (alu_err_s)
  );

  // Grant selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Next-state logic and ready generation; requests are only taken in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_r)
      IDLE: begin
        req0_ready = req0_valid & ~grant_id_s;
        req1_ready = req1_valid & grant_id_s;
        if (any_valid_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, registered response and completion counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      op_r         <= 3'b000;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      id_r         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= {WIDTH{1'b0}};
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            op_r         <= grant_id_s ? req1_op : req0_op;
            a_r          <= grant_id_s ? req1_a  : req0_a;
            b_r          <= grant_id_s ? req1_b  : req0_b;
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
          rsp_data  <= alu_res_s;
          rsp_zero  <= (alu_res_s == {WIDTH{1'b0}});
          rsp_err   <= alu_err_s;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter. A second instance with a 4-bit
// counter sees identical stimulus and is used for the counter-wrap check.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] op_count;

  logic        req0_ready_4, req1_ready_4, rsp_valid_4, rsp_id_4, rsp_zero_4, rsp_err_4;
  logic [31:0] rsp_data_4;
  logic [3:0]  op_count_4;

  int n_pass  = 0;
  int n_total = 0;

  alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  alu_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_id(rsp_id_4),
    .rsp_data(rsp_data_4), .rsp_zero(rsp_zero_4), .rsp_err(rsp_err_4),
    .op_count(op_count_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One complete transaction from a single requester, response taken at once.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d,
                        input logic exp_z, input logic exp_e);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk("ready0", 32'(req0_ready), 32'(!id));
    chk("ready1", 32'(req1_ready), 32'(id));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("exec_no_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_zero", 32'(rsp_zero), 32'(exp_z));
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = 32'd0; req1_b = 32'd0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready0", 32'(req0_ready), 32'd0);

    // ADD overflow wraps into the sign bit
    run_op(1'b0, 3'b100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
    chk("count_1", 32'(op_count), 32'd1);

    // signed compare, reserved opcode, NOR of zeros
    run_op(1'b0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    run_op(1'b0, 3'b111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1);
    run_op(1'b1, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("count_4", 32'(op_count), 32'd4);

    // both requesters continuously valid: strict alternation 0,1,0,1
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'd5;         req1_b = 32'd7;
    rsp_ready  = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_data", rsp_data, (k % 2 == 0) ? 32'hF0F0_0F0F : 32'hFFFF_FFFE);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("count_8", 32'(op_count), 32'd8);

    // backpressure: response held for 10 cycles while req1 waits
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'hFF00_FF00; req1_b = 32'h0F0F_0F0F;
    #1;
    chk("bp_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_first_data", rsp_data, 32'h1234_5678);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h1234_5678);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_idle_ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp2_id", 32'(rsp_id), 32'd1);
    chk("bp2_data", rsp_data, 32'h0F00_0F00);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("count_10", 32'(op_count), 32'd10);
    chk("count4_10", 32'(op_count_4), 32'd10);

    // reset while in EXEC discards the operation
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'd1; req0_b = 32'd1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(rsp_valid), 32'd0);
    end
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'd2; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'd9; req1_b = 32'd4;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_data", rsp_data, 32'd5);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // 16 more completions: 17 since reset, so the 4-bit counter reads 1
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 3'b100, 32'(i), 32'h10, 32'(i + 16), 1'b0, 1'b0);
    end
    chk("count_17", 32'(op_count), 32'd17);
    chk("count4_wrap", 32'(op_count_4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
